stream_mux_n: RTL

Parametrised N-input, WIDTH-bit stream multiplexer with valid/ready handshakes on every input and one registered output stage. It replaces plain 2:1 select muxes wherever several datapath sources compete for one sink, for example the IF and MEM requests sharing a single memory port. Channel selection is either an external select or fair round-robin, chosen at run time. The output is registered, so latency is one cycle and back-pressure is honoured.

---
 rtl/stream_mux_pkg.sv | 17 +
 rtl/rr_arbiter_n.sv | 36 +++
 rtl/stream_mux_n.sv | 94 +++++++++
 3 files changed

// File: rtl/stream_mux_pkg.sv
// Shared definitions for the N-input stream multiplexer.
// Mode encodings and a small width helper.
package stream_mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    function automatic int idx_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin arbiter.
// Picks the first requester at or after ptr, wrapping at N.
module rr_arbiter_n
    import stream_mux_pkg::*;
#(
    parameter  int N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_any
);

    int   j;
    logic found;

    // Rotating first-one search starting at ptr
    always_comb begin
        gnt_idx = '0;
        gnt_any = |req;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && req[j]) begin
                found   = 1'b1;
                gnt_idx = SEL_W'(j);
            end
        end
    end

endmodule

// File: rtl/stream_mux_n.sv
// N-input valid/ready stream mux with one output register.
// Select is external (mode 0) or round-robin (mode 1).
module stream_mux_n
    import stream_mux_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_chan
);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] rr_idx;
    logic             rr_any;
    logic [SEL_W-1:0] grant;
    logic             grant_valid;
    logic             sel_ok;
    logic             load_ok;
    logic             xfer;

    rr_arbiter_n #(
        .N (N)
    ) u_arb (
        .req     (in_valid),
        .ptr     (ptr),
        .gnt_idx (rr_idx),
        .gnt_any (rr_any)
    );

    assign load_ok = !out_valid || out_ready;
    assign sel_ok  = (int'(sel) < N);

    // Mode mux between external select and arbiter
    always_comb begin
        grant       = sel;
        grant_valid = 1'b0;
        if (mode == MODE_RR) begin
            grant       = rr_idx;
            grant_valid = rr_any;
        end else if (sel_ok) begin
            grant_valid = in_valid[sel];
        end
    end

    assign xfer = load_ok && grant_valid;

    // One-hot ready toward the granted channel only
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = xfer && (grant == SEL_W'(i));
        end
    end

    // Output register: load, drain or hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data[int'(grant)*WIDTH +: WIDTH];
            out_chan  <= grant;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Round-robin pointer advances past each RR grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (xfer && mode == MODE_RR) begin
            if (int'(grant) == N - 1) begin
                ptr <= '0;
            end else begin
                ptr <= grant + 1'b1;
            end
        end
    end

endmodule
